// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel and the decode-side queue.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding imem request at a time, responses tagged with
// their PC and queued in a small FIFO for decode; redirect flushes the queue and any in-flight fetch.
module fetch_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  curr_pc_i,
    output logic         pc_enable_o,
    input  logic         redirect_i,
    fetch_unit_if.master bus_io
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDiscard} state_e;

    state_e          state_q, state_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d, count_after;
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];
    logic            push, pop, handshake, not_empty;
    logic            req_valid;
    logic [31:0]     req_addr;

    assign not_empty = (count_q != '0);
    assign pop       = not_empty & bus_io.inst_ready & ~redirect_i;
    // Occupancy after a push in this cycle; only consulted in StWait when a push happens.
    assign count_after = count_q + CntW'(1) - CntW'(pop);

    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        push      = 1'b0;
        handshake = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        unique case (state_q)
            StIdle: begin
                if (!redirect_i && count_q < Full) state_d = StReq;
            end
            StReq: begin
                if (redirect_i) begin
                    state_d = StIdle;
                end else begin
                    req_valid = 1'b1;
                    req_addr  = curr_pc_i;
                    if (bus_io.imem_req_ready) begin
                        handshake = 1'b1;
                        req_pc_d  = curr_pc_i;
                        state_d   = StWait;
                    end
                end
            end
            StWait: begin
                if (redirect_i) begin
                    state_d = bus_io.imem_resp_valid ? StIdle : StDiscard;
                end else if (bus_io.imem_resp_valid) begin
                    push    = 1'b1;
                    state_d = (count_after < Full) ? StReq : StIdle;
                end
            end
            StDiscard: begin
                if (bus_io.imem_resp_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (redirect_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PtrW'(1);
            if (pop)  rptr_d = rptr_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            req_pc_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: the head is only exposed while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wptr_q]   <= req_pc_q;
            data_mem_q[wptr_q] <= bus_io.imem_resp_data;
        end
    end

    assign pc_enable_o           = handshake | redirect_i;
    assign bus_io.imem_req_valid = req_valid;
    assign bus_io.imem_req_addr  = req_addr;
    assign bus_io.inst_valid     = not_empty;
    assign bus_io.inst_pc        = not_empty ? pc_mem_q[rptr_q]   : '0;
    assign bus_io.inst           = not_empty ? data_mem_q[rptr_q] : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model and a PC model feed a
// scoreboard queue of expected {pc, instruction} entries that is checked on every decode pop.
module tb_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] curr_pc;
    logic        pc_enable;
    logic        redirect;
    logic [31:0] target;

    fetch_unit_if bif ();

    fetch_unit #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .curr_pc_i  (curr_pc),
        .pc_enable_o(pc_enable),
        .redirect_i (redirect),
        .bus_io     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_assert;
    int unsigned n_fail;
    exp_t        exp_q[$];

    // Memory model state
    logic        pend;
    logic        kill;
    int unsigned cnt;
    int unsigned lat;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;
    logic        ovr_en;
    logic [31:0] ovr_data;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0001;
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic irdy, input logic rdr);
        bif.imem_req_ready = rdy;
        bif.inst_ready     = irdy;
        redirect           = rdr;
        #1;
    endtask

    // Close the current cycle: scoreboard pop, clock edge, then memory and PC models.
    task automatic step();
        logic        hs, pe, rd, rv, pop;
        logic [31:0] ha;
        exp_t        e;
        hs  = bif.imem_req_valid && bif.imem_req_ready;
        ha  = bif.imem_req_addr;
        pe  = pc_enable;
        rd  = redirect;
        rv  = bif.imem_resp_valid;
        pop = bif.inst_valid && bif.inst_ready && !rd;
        if (pop) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed pop of pc %h, expected no entry", bif.inst_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_inst_pc", bif.inst_pc, e.pc);
                chk("sb_inst", bif.inst, e.data);
            end
        end
        @(posedge clk);
        #1;
        if (rd) exp_q.delete();
        if (rv) begin
            if (!kill && !rd) exp_q.push_back({pend_addr, pend_data});
            pend = 1'b0;
            kill = 1'b0;
        end else if (rd && pend) begin
            kill = 1'b1;
        end
        if (hs) begin
            pend      = 1'b1;
            cnt       = lat;
            pend_addr = ha;
            pend_data = ovr_en ? ovr_data : word(ha);
        end else if (pend) begin
            cnt--;
        end
        bif.imem_resp_valid = pend && (cnt == 1);
        bif.imem_resp_data  = bif.imem_resp_valid ? pend_data : 32'h0;
        if (pe) curr_pc = rd ? target : curr_pc + 32'd4;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc_enable"}, {31'b0, pc_enable}, 32'd0);
        chk({tag, "_req_valid"}, {31'b0, bif.imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, bif.imem_req_addr, 32'd0);
        chk({tag, "_inst_valid"}, {31'b0, bif.inst_valid}, 32'd0);
        chk({tag, "_inst_pc"}, bif.inst_pc, 32'd0);
        chk({tag, "_inst"}, bif.inst, 32'd0);
    endtask

    initial begin
        logic found;
        n_assert = 0;
        n_fail   = 0;
        pend = 1'b0; kill = 1'b0; cnt = 0; lat = 1;
        pend_addr = '0; pend_data = '0; ovr_en = 1'b0; ovr_data = '0;
        rst_n = 1'b0; curr_pc = 32'h0000_3000; redirect = 1'b0; target = '0;
        bif.imem_req_ready = 1'b0; bif.imem_resp_valid = 1'b0;
        bif.imem_resp_data = '0; bif.inst_ready = 1'b0;
        #3;
        chk_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;

        // Basic fetch
        drive(1, 0, 0);
        chk("idle_req_valid", {31'b0, bif.imem_req_valid}, 32'd0);
        chk("idle_pc_enable", {31'b0, pc_enable}, 32'd0);
        step();
        drive(1, 0, 0);
        chk("req_valid", {31'b0, bif.imem_req_valid}, 32'd1);
        chk("req_addr", bif.imem_req_addr, 32'h0000_3000);
        chk("req_pc_enable", {31'b0, pc_enable}, 32'd1);
        step();
        drive(1, 0, 0);
        chk("wait_pc_enable", {31'b0, pc_enable}, 32'd0);
        chk("wait_req_valid", {31'b0, bif.imem_req_valid}, 32'd0);
        chk("wait_inst_valid", {31'b0, bif.inst_valid}, 32'd0);
        step();
        drive(1, 0, 0);
        chk("first_inst_valid", {31'b0, bif.inst_valid}, 32'd1);
        chk("first_inst_pc", bif.inst_pc, 32'h0000_3000);
        chk("first_inst", bif.inst, 32'h2408_0001);
        chk("second_req_addr", bif.imem_req_addr, 32'h0000_3004);

        // Fill to full: three more fetches then the FSM parks
        for (int i = 0; i < 6; i++) begin
            step();
            drive(1, 0, 0);
        end
        chk("full_curr_pc", curr_pc, 32'h0000_3010);
        chk("full_inst_pc", bif.inst_pc, 32'h0000_3000);
        for (int i = 0; i < 3; i++) begin
            chk("full_req_valid", {31'b0, bif.imem_req_valid}, 32'd0);
            chk("full_pc_enable", {31'b0, pc_enable}, 32'd0);
            step();
            drive(1, 0, 0);
        end
        drive(1, 1, 0);
        step();
        drive(1, 0, 0);
        chk("after_pop_req_valid", {31'b0, bif.imem_req_valid}, 32'd0);
        chk("after_pop_inst_pc", bif.inst_pc, 32'h0000_3004);
        step();

        // Back-pressure on the request channel
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0);
            chk("bp_req_valid", {31'b0, bif.imem_req_valid}, 32'd1);
            chk("bp_req_addr", bif.imem_req_addr, 32'h0000_3010);
            chk("bp_pc_enable", {31'b0, pc_enable}, 32'd0);
            step();
        end
        drive(1, 0, 0);
        chk("bp_hs_pc_enable", {31'b0, pc_enable}, 32'd1);
        chk("bp_hs_req_addr", bif.imem_req_addr, 32'h0000_3010);
        step();
        drive(1, 0, 0);
        step();

        // Concurrent push/pop streaming, order checked by the scoreboard
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0);
            step();
        end

        // Redirect while a slow fetch is in flight
        lat      = 3;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        found    = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            drive(1, 1, 0);
            if (bif.imem_req_valid) found = 1'b1;
            else step();
        end
        chk("found_req", {31'b0, found}, 32'd1);
        step();
        ovr_en = 1'b0;
        lat    = 1;
        target = 32'h0000_8000;
        drive(1, 0, 1);
        chk("redir_pc_enable", {31'b0, pc_enable}, 32'd1);
        chk("redir_req_valid", {31'b0, bif.imem_req_valid}, 32'd0);
        step();
        drive(1, 0, 0);
        chk("flush_inst_valid", {31'b0, bif.inst_valid}, 32'd0);
        chk("flush_pc_enable", {31'b0, pc_enable}, 32'd0);
        chk("discard_req_valid", {31'b0, bif.imem_req_valid}, 32'd0);
        chk("target_pc", curr_pc, 32'h0000_8000);
        step();
        drive(1, 0, 0);
        chk("stale_resp_valid", {31'b0, bif.imem_resp_valid}, 32'd1);
        chk("stale_req_valid", {31'b0, bif.imem_req_valid}, 32'd0);
        step();
        drive(1, 0, 0);
        chk("stale_dropped", {31'b0, bif.inst_valid}, 32'd0);
        step();

        // Redirect during REQ suppresses the request
        target = 32'h0000_9000;
        drive(1, 0, 1);
        chk("req_redir_valid", {31'b0, bif.imem_req_valid}, 32'd0);
        chk("req_redir_pc_enable", {31'b0, pc_enable}, 32'd1);
        step();
        drive(1, 0, 0);
        chk("req_redir_idle", {31'b0, bif.imem_req_valid}, 32'd0);
        step();
        drive(1, 0, 0);
        chk("new_req_valid", {31'b0, bif.imem_req_valid}, 32'd1);
        chk("new_req_addr", bif.imem_req_addr, 32'h0000_9000);
        step();
        drive(1, 0, 0);
        step();
        drive(1, 0, 0);
        chk("new_inst_valid", {31'b0, bif.inst_valid}, 32'd1);
        chk("new_inst_pc", bif.inst_pc, 32'h0000_9000);
        chk("new_inst", bif.inst, 32'h6FFF_9000);

        // Asynchronous reset while waiting on a response
        lat = 3;
        chk("pre_rst_req_addr", bif.imem_req_addr, 32'h0000_9004);
        step();
        drive(1, 0, 0);
        chk("pre_rst_inst_valid", {31'b0, bif.inst_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        pend = 1'b0; kill = 1'b0;
        bif.imem_resp_valid = 1'b0;
        bif.imem_resp_data  = '0;
        exp_q.delete();
        step();
        step();
        rst_n   = 1'b1;
        curr_pc = 32'h0000_A000;
        lat     = 1;
        drive(1, 0, 0);
        chk("restart_idle", {31'b0, bif.imem_req_valid}, 32'd0);
        step();
        drive(1, 1, 0);
        chk("restart_req_addr", bif.imem_req_addr, 32'h0000_A000);
        step();
        drive(1, 1, 0);
        step();
        drive(1, 1, 0);
        chk("restart_inst_pc", bif.inst_pc, 32'h0000_A000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that consumes the program counter's current value and drives the program counter's advance enable.
- Issues one-at-a-time requests to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions, each tagged with its PC, in a small FIFO that feeds decode.
- Handles redirect (branch/jump) by flushing the buffer and discarding any in-flight response.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- curr_pc  in  32  current program counter value.
- pc_enable  out  1  advance enable to the program counter; `PC_ENABLED (1) = load next_pc on this edge.
- redirect  in  1  one-cycle pulse: control flow changed, so flush the buffer; next_pc already selects the target this cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  FIFO head valid (FIFO not empty).
- inst_pc  out  32  PC of the head entry.
- inst  out  32  instruction word of the head entry.
- inst_ready  in  1  decode consumes the head entry this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, FIFO empty (count=0, read/write pointers 0).
  - pc_enable=0, imem_req_valid=0, imem_req_addr=0, inst_valid=0, inst_pc=0, inst=0.
  - Any outstanding request is forgotten; the memory is reset in the same domain.
- FSM states: IDLE, REQ, WAIT, DISCARD.
  - IDLE: if !redirect and count<DEPTH -> REQ next cycle; otherwise stay.
  - REQ:
    - imem_req_valid=1, imem_req_addr=curr_pc (combinational).
    - On imem_req_ready=1: pc_enable=1 in the same cycle, latch addr into req_pc, -> WAIT.
    - If redirect=1 in REQ: imem_req_valid is forced 0 that cycle and no handshake occurs; -> IDLE.
  - WAIT:
    - On imem_resp_valid: push {req_pc, imem_resp_data}.
    - Next state after the push: REQ if count after this cycle's push/pop < DEPTH, else IDLE.
  - DISCARD: on imem_resp_valid, drop the data (no push) -> IDLE.
- Redirect:
  - FIFO cleared at the next edge: count=0 and pointers reset. A same-cycle pop and push are both suppressed.
  - pc_enable=1 during the redirect cycle so the pc loads the target.
  - In WAIT without a same-cycle response: -> DISCARD.
  - In WAIT with a same-cycle response: response dropped, -> IDLE.
  - In IDLE or DISCARD: state is unchanged, except DISCARD -> IDLE if a response also arrives.
- pc_enable is 1 only on an accepted request or a redirect; otherwise 0. Never 1 for two consecutive cycles without a handshake or redirect.
- FIFO:
  - Pop when inst_valid & inst_ready & !redirect.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - A push never occurs while full, because a request is only issued when count<DEPTH and pops only free space.
  - inst, inst_pc and inst_valid are driven from the head entry (registered storage, no bypass). Push-to-visible latency is 1 cycle.
- Steady-state throughput:
  - Zero-latency-ready memory with 1-cycle response gives one instruction per 2 cycles (REQ, WAIT).
  - There is at most one outstanding request.
- Misaligned curr_pc (low 2 bits != 0) is fetched as-is; alignment checks belong elsewhere.

Test Plan:
- Reset and basic fetch:
  - Stimulus: reset, curr_pc=0x3000, imem_req_ready=1, response 1 cycle later with 0x24080001, inst_ready=0.
  - Required: pc_enable pulses once, then inst_valid=1, inst_pc=0x3000, inst=0x24080001.
- Fill to full:
  - Stimulus: inst_ready=0, 4 sequential fetches (pc 0x3000..0x300C).
  - Required: count=4, FSM parks in IDLE, imem_req_valid=0, pc_enable stays 0 until a pop.
- Back-pressure on request:
  - Stimulus: imem_req_ready=0 for 3 cycles.
  - Required: imem_req_valid held at 1 with a stable address, pc_enable=0 throughout, asserted only in the handshake cycle.
- Simultaneous push and pop:
  - Stimulus: FIFO count=2, response arrives while inst_ready=1.
  - Required: count stays 2 and head advances in order; inst_pc sequence is 0x3000, 0x3004, 0x3008 with no gaps.
- Redirect with request in flight:
  - Stimulus: redirect in WAIT, response 2 cycles later with 0xDEADBEEF.
  - Required: FIFO empty the next cycle, 0xDEADBEEF never appears on inst, next request uses the new curr_pc.
- Asynchronous reset mid-WAIT:
  - Stimulus: drop rst_n between edges while in WAIT.
  - Required: all outputs 0 immediately, without waiting for a clock edge; after release, fetch restarts from curr_pc.
